// File: rtl/demux_tdm4_if.sv
// Bus bundle for the four-channel TDM demultiplexer: serial input side plus word outputs.
// The error pulse is only present when DEMUX_SYNC_ERR_EN is defined.
interface demux_tdm4_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             dato;
  logic             sync;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [1:0]       selector;
  logic             listo;
`ifdef DEMUX_SYNC_ERR_EN
  logic             error;

  modport master (
    output enable, dato, sync,
    input  A, B, C, D, selector, listo, error
  );

  modport slave (
    input  enable, dato, sync,
    output A, B, C, D, selector, listo, error
  );
`else
  modport master (
    output enable, dato, sync,
    input  A, B, C, D, selector, listo
  );

  modport slave (
    input  enable, dato, sync,
    output A, B, C, D, selector, listo
  );
`endif
endinterface

// File: rtl/demux_tdm4.sv
// Four-channel bit-interleaved TDM demultiplexer framed by a sync pulse.
// Optional framing-error pulse on resync is enabled by defining DEMUX_SYNC_ERR_EN.
module demux_tdm4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  demux_tdm4_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(4 * WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(4 * WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sh_q [4];
  logic [WIDTH-1:0] sh_d [4];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             listo_q, listo_d;
`ifdef DEMUX_SYNC_ERR_EN
  logic             error_q, error_d;
`endif

  logic [1:0] slot;
  assign slot = count_q[1:0];

  // Next-state: frame counting, per-slot shifting, word hand-off and resync.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sh_d    = sh_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    listo_d = 1'b0;
`ifdef DEMUX_SYNC_ERR_EN
    error_d = 1'b0;
`endif

    if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sync) begin
            state_d = RUN;
            count_d = CNT_W'(1);
            for (int s = 0; s < 4; s++) sh_d[s] = '0;
            sh_d[0] = WIDTH'(bus.dato);
          end
        end
        RUN: begin
          if (bus.sync && (count_q != '0)) begin
            // Resync: drop the partial frame, this bit starts a new one.
            count_d = CNT_W'(1);
            for (int s = 0; s < 4; s++) sh_d[s] = '0;
            sh_d[0] = WIDTH'(bus.dato);
`ifdef DEMUX_SYNC_ERR_EN
            error_d = 1'b1;
`endif
          end else begin
            for (int s = 0; s < 4; s++) begin
              if (2'(s) == slot) sh_d[s] = {sh_q[s][WIDTH-2:0], bus.dato};
            end
            if (count_q == LAST) begin
              count_d = '0;
              a_d     = sh_d[0];
              b_d     = sh_d[1];
              c_d     = sh_d[2];
              d_d     = sh_d[3];
              listo_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      for (int s = 0; s < 4; s++) sh_q[s] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      listo_q <= 1'b0;
`ifdef DEMUX_SYNC_ERR_EN
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int s = 0; s < 4; s++) sh_q[s] <= sh_d[s];
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      listo_q <= listo_d;
`ifdef DEMUX_SYNC_ERR_EN
      error_q <= error_d;
`endif
    end
  end

  // count is zero in IDLE, so the slot of the next bit is always its low two bits.
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.C        = c_q;
  assign bus.D        = d_q;
  assign bus.selector = count_q[1:0];
  assign bus.listo    = listo_q;
`ifdef DEMUX_SYNC_ERR_EN
  assign bus.error    = error_q;
`endif

endmodule

// File: tb/tb_demux_tdm4.sv
// Directed self-checking bench for demux_tdm4 at WIDTH = 4.
// Error-pulse checks are compiled in only when DEMUX_SYNC_ERR_EN is defined.
module tb_demux_tdm4;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  demux_tdm4_if #(.WIDTH(W)) bus ();

  demux_tdm4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] outs();
    return {bus.A, bus.B, bus.C, bus.D};
  endfunction

  // Bit k of a frame; w packs {A,B,C,D} with A in the top nibble.
  function automatic logic fbit(input logic [15:0] w, input int k);
    int slot;
    int b;
    logic [3:0] word;
    slot = k % 4;
    b    = 3 - k / 4;
    word = w[15 - slot*4 -: 4];
    return word[b];
  endfunction

  task automatic step(input logic en, input logic d, input logic s);
    bus.enable = en;
    bus.dato   = d;
    bus.sync   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs() !== 16'h0000) begin
      failures++; $display("FAIL reset_words got=%h exp=0000", outs());
    end
    checks++;
    if (bus.selector !== 2'b00) begin
      failures++; $display("FAIL reset_selector got=%b exp=00", bus.selector);
    end
    checks++;
    if (bus.listo !== 1'b0) begin
      failures++; $display("FAIL reset_listo got=%b exp=0", bus.listo);
    end
`ifdef DEMUX_SYNC_ERR_EN
    checks++;
    if (bus.error !== 1'b0) begin
      failures++; $display("FAIL reset_error got=%b exp=0", bus.error);
    end
`endif
  endtask

  task automatic test_single_frame();
    logic [15:0] w;
    w = 16'hA5F0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, fbit(w, k), k == 0);
      checks++;
      if (bus.selector !== 2'((k + 1) % 4)) begin
        failures++; $display("FAIL single_selector k=%0d got=%b exp=%b", k, bus.selector, 2'((k + 1) % 4));
      end
      if (k < 15) begin
        checks++;
        if (bus.listo !== 1'b0) begin
          failures++; $display("FAIL single_listo_early k=%0d got=%b exp=0", k, bus.listo);
        end
      end
    end
    checks++;
    if (outs() !== w) begin
      failures++; $display("FAIL single_words got=%h exp=%h", outs(), w);
    end
    checks++;
    if (bus.listo !== 1'b1) begin
      failures++; $display("FAIL single_listo got=%b exp=1", bus.listo);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.listo !== 1'b0) begin
      failures++; $display("FAIL single_listo_width got=%b exp=0", bus.listo);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2, w;
    logic        exp_listo;
    w1 = 16'h96C3;
    w2 = 16'h1234;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      w = (c < 16) ? w1 : w2;
      step(1'b1, fbit(w, c % 16), c == 0);
      exp_listo = (c == 15) || (c == 31);
      checks++;
      if (bus.listo !== exp_listo) begin
        failures++; $display("FAIL b2b_listo cycle=%0d got=%b exp=%b", c + 1, bus.listo, exp_listo);
      end
      if (c == 15 || c == 31) begin
        checks++;
        if (outs() !== w) begin
          failures++; $display("FAIL b2b_words cycle=%0d got=%h exp=%h", c + 1, outs(), w);
        end
      end
    end
  endtask

  task automatic test_resync();
    logic [15:0] wp, wn;
    wp = 16'hFFFF;
    wn = 16'h78E1;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, fbit(wp, k), k == 0);
      checks++;
      if (bus.listo !== 1'b0) begin
        failures++; $display("FAIL resync_partial_listo k=%0d got=%b exp=0", k, bus.listo);
      end
`ifdef DEMUX_SYNC_ERR_EN
      checks++;
      if (bus.error !== 1'b0) begin
        failures++; $display("FAIL resync_partial_error k=%0d got=%b exp=0", k, bus.error);
      end
`endif
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, fbit(wn, k), k == 0);
      checks++;
      if (bus.listo !== (k == 15)) begin
        failures++; $display("FAIL resync_listo k=%0d got=%b exp=%b", k, bus.listo, k == 15);
      end
`ifdef DEMUX_SYNC_ERR_EN
      checks++;
      if (bus.error !== (k == 0)) begin
        failures++; $display("FAIL resync_error k=%0d got=%b exp=%b", k, bus.error, k == 0);
      end
`endif
      if (k == 0 || k == 14) begin
        checks++;
        if (outs() !== 16'h1234) begin
          failures++; $display("FAIL resync_hold k=%0d got=%h exp=1234", k, outs());
        end
      end
    end
    checks++;
    if (outs() !== wn) begin
      failures++; $display("FAIL resync_words got=%h exp=%h", outs(), wn);
    end
  endtask

  task automatic test_sync_last();
    logic [15:0] wd, wn;
    wd = 16'h5555;
    wn = 16'hBEEF;
    for (int k = 0; k < 15; k++) step(1'b1, fbit(wd, k), 1'b0);
    step(1'b1, fbit(wn, 0), 1'b1);
    checks++;
    if (bus.listo !== 1'b0) begin
      failures++; $display("FAIL synclast_listo got=%b exp=0", bus.listo);
    end
    checks++;
    if (outs() !== 16'h78E1) begin
      failures++; $display("FAIL synclast_hold got=%h exp=78e1", outs());
    end
    checks++;
    if (bus.selector !== 2'b01) begin
      failures++; $display("FAIL synclast_selector got=%b exp=01", bus.selector);
    end
`ifdef DEMUX_SYNC_ERR_EN
    checks++;
    if (bus.error !== 1'b1) begin
      failures++; $display("FAIL synclast_error got=%b exp=1", bus.error);
    end
`endif
    for (int k = 1; k < 16; k++) step(1'b1, fbit(wn, k), 1'b0);
    checks++;
    if (outs() !== wn || bus.listo !== 1'b1) begin
      failures++; $display("FAIL synclast_words got=%h listo=%b exp=%h listo=1", outs(), bus.listo, wn);
    end
  endtask

  task automatic test_enable_hold();
    logic [15:0] w;
    w = 16'h3C5A;
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, fbit(w, k), k == 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (bus.selector !== 2'b01 || bus.listo !== 1'b0) begin
        failures++; $display("FAIL hold_frozen i=%0d got sel=%b listo=%b exp sel=01 listo=0", i, bus.selector, bus.listo);
      end
`ifdef DEMUX_SYNC_ERR_EN
      checks++;
      if (bus.error !== 1'b0) begin
        failures++; $display("FAIL hold_error i=%0d got=%b exp=0", i, bus.error);
      end
`endif
    end
    for (int k = 5; k < 16; k++) step(1'b1, fbit(w, k), 1'b0);
    checks++;
    if (outs() !== w || bus.listo !== 1'b1) begin
      failures++; $display("FAIL hold_words got=%h listo=%b exp=%h listo=1", outs(), bus.listo, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] wp, w;
    wp = 16'h9999;
    w  = 16'h6A0F;
    for (int k = 0; k < 9; k++) step(1'b1, fbit(wp, k), k == 0);
    reset = 1'b1;
    step(1'b1, fbit(wp, 9), 1'b0);
    reset = 1'b0;
    checks++;
    if (outs() !== 16'h0000 || bus.selector !== 2'b00 || bus.listo !== 1'b0) begin
      failures++; $display("FAIL midreset_state got=%h sel=%b listo=%b exp=0000 sel=00 listo=0", outs(), bus.selector, bus.listo);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.listo !== 1'b0 || bus.selector !== 2'b00) begin
        failures++; $display("FAIL midreset_idle i=%0d got listo=%b sel=%b exp listo=0 sel=00", i, bus.listo, bus.selector);
      end
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, fbit(w, k), k == 0);
      checks++;
      if (bus.listo !== (k == 15)) begin
        failures++; $display("FAIL midreset_listo k=%0d got=%b exp=%b", k, bus.listo, k == 15);
      end
    end
    checks++;
    if (outs() !== w) begin
      failures++; $display("FAIL midreset_words got=%h exp=%h", outs(), w);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.dato   = 1'b0;
    bus.sync   = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_resync();
    test_sync_last();
    test_enable_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
